// File: rtl/prf_free_list.sv
// rtl/prf_free_list.sv - physical register free list: circular FIFO of free IDs plus in-list bitmap
module prf_free_list #(
  parameter int PRF_SIZE  = 16,
  parameter int ARCH_REGS = 4,
  localparam int IDW      = $clog2(PRF_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_req,
  output logic                alloc_valid,
  output logic [IDW-1:0]      alloc_id,
  output logic                alloc_grant,
  input  logic                free_ena,
  input  logic [IDW-1:0]      free_id,
  output logic [IDW:0]        free_count,
  output logic [PRF_SIZE-1:0] in_list,
  output logic                err_overflow,
  output logic                err_double,
  input  logic                err_clr
);

  localparam logic [IDW:0]   FULL_CNT = (IDW+1)'(PRF_SIZE);
  localparam logic [IDW:0]   RST_CNT  = (IDW+1)'(PRF_SIZE - ARCH_REGS);
  localparam logic [IDW-1:0] RST_TAIL = IDW'(PRF_SIZE - ARCH_REGS);

  logic [IDW-1:0]      mem_q [PRF_SIZE];
  logic [IDW-1:0]      mem_d [PRF_SIZE];
  logic [IDW-1:0]      head_q, head_d;
  logic [IDW-1:0]      tail_q, tail_d;
  logic [IDW:0]        count_q, count_d;
  logic [PRF_SIZE-1:0] in_list_q, in_list_d;
  logic                err_overflow_q, err_overflow_d;
  logic                err_double_q, err_double_d;

  logic grant;
  logic accept;
  logic is_double;
  logic full;

  assign full      = (count_q == FULL_CNT);
  assign is_double = free_ena & in_list_q[free_id];
  assign accept    = free_ena & ~in_list_q[free_id] & ~full;
  // Gated by rst_n so an asserted reset never leaks a grant to rename.
  assign grant     = rst_n & alloc_req & (count_q != '0);

  always_comb begin
    for (int i = 0; i < PRF_SIZE; i++) mem_d[i] = mem_q[i];
    head_d         = head_q;
    tail_d         = tail_q;
    in_list_d      = in_list_q;
    count_d        = count_q;
    err_overflow_d = err_clr ? 1'b0 : err_overflow_q;
    err_double_d   = err_clr ? 1'b0 : err_double_q;

    if (grant) begin
      head_d                  = head_q + 1'b1;
      in_list_d[mem_q[head_q]] = 1'b0;
    end
    if (accept) begin
      mem_d[tail_q]      = free_id;
      tail_d             = tail_q + 1'b1;
      in_list_d[free_id] = 1'b1;
    end
    case ({accept, grant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Double-free outranks overflow; a new error beats a same-cycle clear.
    if (is_double) err_double_d = 1'b1;
    else if (free_ena && full) err_overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PRF_SIZE; i++) begin
        mem_q[i]     <= (i < PRF_SIZE - ARCH_REGS) ? IDW'(ARCH_REGS + i) : '0;
        in_list_q[i] <= (i >= ARCH_REGS);
      end
      head_q         <= '0;
      tail_q         <= RST_TAIL;
      count_q        <= RST_CNT;
      err_overflow_q <= 1'b0;
      err_double_q   <= 1'b0;
    end else begin
      for (int i = 0; i < PRF_SIZE; i++) mem_q[i] <= mem_d[i];
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      in_list_q      <= in_list_d;
      err_overflow_q <= err_overflow_d;
      err_double_q   <= err_double_d;
    end
  end

  assign alloc_valid  = (count_q != '0);
  assign alloc_id     = mem_q[head_q];
  assign alloc_grant  = grant;
  assign free_count   = count_q;
  assign in_list      = in_list_q;
  assign err_overflow = err_overflow_q;
  assign err_double   = err_double_q;

endmodule

// File: tb/tb_prf_free_list.sv
// tb/tb_prf_free_list.sv - directed bench for prf_free_list (PRF_SIZE=16, ARCH_REGS=4)
module tb_prf_free_list;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_req;
  logic        alloc_valid;
  logic [3:0]  alloc_id;
  logic        alloc_grant;
  logic        free_ena;
  logic [3:0]  free_id;
  logic [4:0]  free_count;
  logic [15:0] in_list;
  logic        err_overflow;
  logic        err_double;
  logic        err_clr;

  int vectors = 0;
  int miscompares = 0;

  prf_free_list #(.PRF_SIZE(16), .ARCH_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_id(alloc_id), .alloc_grant(alloc_grant), .free_ena(free_ena),
    .free_id(free_id), .free_count(free_count), .in_list(in_list),
    .err_overflow(err_overflow), .err_double(err_double), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; alloc_req = 1'b0; free_ena = 1'b0; free_id = '0; err_clr = 1'b0;
    #12;
    vectors++; if (alloc_valid !== 1'b1) begin miscompares++; $display("FAIL reset_valid got %b exp 1", alloc_valid); end
    vectors++; if (alloc_id !== 4'd4) begin miscompares++; $display("FAIL reset_id got %0d exp 4", alloc_id); end
    vectors++; if (free_count !== 5'd12) begin miscompares++; $display("FAIL reset_count got %0d exp 12", free_count); end
    vectors++; if (in_list !== 16'hFFF0) begin miscompares++; $display("FAIL reset_in_list got %h exp fff0", in_list); end
    vectors++; if ({err_overflow, err_double} !== 2'b00) begin miscompares++; $display("FAIL reset_errs got %b exp 00", {err_overflow, err_double}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_drain;
    alloc_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      vectors++; if (alloc_grant !== 1'b1) begin miscompares++; $display("FAIL drain_grant[%0d] got %b exp 1", i, alloc_grant); end
      vectors++; if (alloc_id !== 4'(4 + i)) begin miscompares++; $display("FAIL drain_id[%0d] got %0d exp %0d", i, alloc_id, 4 + i); end
      tick();
    end
    #1;
    vectors++; if (alloc_valid !== 1'b0) begin miscompares++; $display("FAIL empty_valid got %b exp 0", alloc_valid); end
    vectors++; if (alloc_grant !== 1'b0) begin miscompares++; $display("FAIL empty_grant got %b exp 0", alloc_grant); end
    vectors++; if (free_count !== 5'd0) begin miscompares++; $display("FAIL empty_count got %0d exp 0", free_count); end
    vectors++; if (in_list !== 16'h0000) begin miscompares++; $display("FAIL empty_in_list got %h exp 0000", in_list); end
    tick();
  endtask

  task automatic test_empty_free;
    alloc_req = 1'b1; free_ena = 1'b1; free_id = 4'd1;
    #1;
    vectors++; if (alloc_grant !== 1'b0) begin miscompares++; $display("FAIL nobypass_grant got %b exp 0", alloc_grant); end
    tick();
    free_ena = 1'b0;
    #1;
    vectors++; if (alloc_valid !== 1'b1) begin miscompares++; $display("FAIL refill_valid got %b exp 1", alloc_valid); end
    vectors++; if (alloc_id !== 4'd1) begin miscompares++; $display("FAIL refill_id got %0d exp 1", alloc_id); end
    vectors++; if (alloc_grant !== 1'b1) begin miscompares++; $display("FAIL refill_grant got %b exp 1", alloc_grant); end
    tick();
    alloc_req = 1'b0;
    vectors++; if (free_count !== 5'd0) begin miscompares++; $display("FAIL refill_count got %0d exp 0", free_count); end
  endtask

  task automatic test_simultaneous;
    logic [3:0] exp_ids [5];
    exp_ids[0] = 4'd9; exp_ids[1] = 4'd10; exp_ids[2] = 4'd11; exp_ids[3] = 4'd12; exp_ids[4] = 4'd2;
    free_ena = 1'b1;
    for (int i = 0; i < 5; i++) begin
      free_id = 4'(8 + i);
      tick();
    end
    vectors++; if (free_count !== 5'd5) begin miscompares++; $display("FAIL sim_pre_count got %0d exp 5", free_count); end
    alloc_req = 1'b1; free_id = 4'd2;
    #1;
    vectors++; if (alloc_grant !== 1'b1 || alloc_id !== 4'd8) begin miscompares++; $display("FAIL sim_grant got %b/%0d exp 1/8", alloc_grant, alloc_id); end
    tick();
    free_ena = 1'b0; alloc_req = 1'b0;
    vectors++; if (free_count !== 5'd5) begin miscompares++; $display("FAIL sim_count got %0d exp 5", free_count); end
    vectors++; if (in_list !== 16'h1E04) begin miscompares++; $display("FAIL sim_in_list got %h exp 1e04", in_list); end
    alloc_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (alloc_grant !== 1'b1 || alloc_id !== exp_ids[i]) begin miscompares++; $display("FAIL sim_order[%0d] got %b/%0d exp 1/%0d", i, alloc_grant, alloc_id, exp_ids[i]); end
      tick();
    end
    alloc_req = 1'b0;
    vectors++; if (free_count !== 5'd0) begin miscompares++; $display("FAIL sim_end_count got %0d exp 0", free_count); end
  endtask

  task automatic test_errors;
    free_ena = 1'b1; free_id = 4'd7;
    tick();
    tick();
    free_ena = 1'b0;
    vectors++; if (err_double !== 1'b1) begin miscompares++; $display("FAIL dbl_flag got %b exp 1", err_double); end
    vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("FAIL dbl_ovf got %b exp 0", err_overflow); end
    vectors++; if (free_count !== 5'd1) begin miscompares++; $display("FAIL dbl_count got %0d exp 1", free_count); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if (err_double !== 1'b0) begin miscompares++; $display("FAIL clr_flag got %b exp 0", err_double); end
    free_ena = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i != 7) begin
        free_id = 4'(i);
        tick();
      end
    end
    free_ena = 1'b0;
    vectors++; if (free_count !== 5'd16) begin miscompares++; $display("FAIL full_count got %0d exp 16", free_count); end
    vectors++; if (in_list !== 16'hFFFF) begin miscompares++; $display("FAIL full_in_list got %h exp ffff", in_list); end
    vectors++; if (err_double !== 1'b0 || err_overflow !== 1'b0) begin miscompares++; $display("FAIL fill_errs got %b%b exp 00", err_overflow, err_double); end
    // At full every ID is in the list, so the double-free check takes priority over overflow.
    free_ena = 1'b1; free_id = 4'd3; err_clr = 1'b1;
    tick();
    free_ena = 1'b0; err_clr = 1'b0;
    vectors++; if (err_double !== 1'b1) begin miscompares++; $display("FAIL full_dbl got %b exp 1", err_double); end
    vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("FAIL full_ovf got %b exp 0", err_overflow); end
    vectors++; if (free_count !== 5'd16) begin miscompares++; $display("FAIL full_hold got %0d exp 16", free_count); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if ({err_overflow, err_double} !== 2'b00) begin miscompares++; $display("FAIL clr2 got %b exp 00", {err_overflow, err_double}); end
  endtask

  task automatic test_reset_mid;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    alloc_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    alloc_req = 1'b0; free_ena = 1'b1; free_id = 4'd9;
    tick();
    free_ena = 1'b0; alloc_req = 1'b1;
    #1;
    vectors++; if (err_double !== 1'b1 || alloc_id !== 4'd7 || free_count !== 5'd9) begin miscompares++; $display("FAIL mid_pre got %b/%0d/%0d exp 1/7/9", err_double, alloc_id, free_count); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (alloc_grant !== 1'b0) begin miscompares++; $display("FAIL mid_grant got %b exp 0", alloc_grant); end
    vectors++; if (alloc_valid !== 1'b1 || alloc_id !== 4'd4) begin miscompares++; $display("FAIL mid_head got %b/%0d exp 1/4", alloc_valid, alloc_id); end
    vectors++; if (free_count !== 5'd12 || in_list !== 16'hFFF0) begin miscompares++; $display("FAIL mid_state got %0d/%h exp 12/fff0", free_count, in_list); end
    vectors++; if (err_double !== 1'b0) begin miscompares++; $display("FAIL mid_err got %b exp 0", err_double); end
    rst_n = 1'b1;
    #1;
    vectors++; if (alloc_grant !== 1'b1 || alloc_id !== 4'd4) begin miscompares++; $display("FAIL post_grant got %b/%0d exp 1/4", alloc_grant, alloc_id); end
    tick();
    alloc_req = 1'b0;
    vectors++; if (alloc_id !== 4'd5 || free_count !== 5'd11) begin miscompares++; $display("FAIL post_pop got %0d/%0d exp 5/11", alloc_id, free_count); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_empty_free();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
